aes_word_serializer: RTL and testbench

//  Upstream feeder for the 128->32 word-select stage. Accepts a 128-bit AES state

---
 rtl/aes_word_serializer.sv | 122 ++++++++++++
 tb/tb_aes_word_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aes_word_serializer.sv
// Serialises a 128-bit AES state block into NUM_WORDS words, most-significant word first.
// Back-to-back blocks load on the last-word handshake so the output stream has no bubble.
module aes_word_serializer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] in_block,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_word,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last,
  output logic                        busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t                        state_r, state_nxt_s;
  logic [IDX_W-1:0]              idx_r, idx_nxt_s;
  logic [WORD_W*NUM_WORDS-1:0]   hold_r, hold_nxt_s;
  logic                          last_s;
  logic [WORD_W-1:0]             words_s [NUM_WORDS];

  // Word g of the held block; word 0 sits in the most-significant bits.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
    assign words_s[g] = hold_r[(NUM_WORDS-1-g)*WORD_W +: WORD_W];
  end

  assign last_s = (idx_r == LAST_IDX);

  // State, index and hold registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= IDX_ZERO;
      hold_r  <= {(WORD_W*NUM_WORDS){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  // Next-state logic: load on accept, step the index on each consumed word.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    hold_nxt_s  = hold_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = SEND;
          idx_nxt_s   = IDX_ZERO;
          hold_nxt_s  = in_block;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_s) begin
            idx_nxt_s = IDX_ZERO;
            // A waiting block is taken in the same cycle as the last word leaves.
            if (in_valid) begin
              state_nxt_s = SEND;
              hold_nxt_s  = in_block;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = IDX_ZERO;
      end
    endcase
  end

  // Output decode from the registered state; only in_ready sees out_ready and rst.
  always_comb begin
    out_valid = 1'b0;
    out_word  = {WORD_W{1'b0}};
    out_idx   = IDX_ZERO;
    out_last  = 1'b0;
    busy      = 1'b0;
    in_ready  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = ~rst;
      end
      SEND: begin
        out_valid = 1'b1;
        out_word  = words_s[idx_r];
        out_idx   = idx_r;
        out_last  = last_s;
        busy      = 1'b1;
        in_ready  = ~rst & last_s & out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_word_serializer.sv
// Directed bench for aes_word_serializer: a per-cycle vector table plus hand-written
// sequences for early in_valid (scoreboarded) and reset in the middle of a block.
module tb_aes_word_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] B2 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
  localparam logic [31:0] W10 = 32'h00112233, W11 = 32'h44556677,
                          W12 = 32'h8899AABB, W13 = 32'hCCDDEEFF;
  localparam logic [31:0] W20 = 32'hA0A0A0A0, W21 = 32'hB1B1B1B1,
                          W22 = 32'hC2C2C2C2, W23 = 32'hD3D3D3D3;

  aes_word_serializer #(.WORD_W(32), .NUM_WORDS(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         iv;
    logic [127:0] blk;
    logic         ordy;
    logic         ov;
    logic [31:0]  w;
    logic [1:0]   idx;
    logic         last;
    logic         irdy;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic [127:0] blk,
                              input logic ordy, input logic ov, input logic [31:0] w,
                              input logic [1:0] idx, input logic last, input logic irdy,
                              input logic bsy);
    vec_t v;
    v.rst = r; v.iv = iv; v.blk = blk; v.ordy = ordy;
    v.ov = ov; v.w = w; v.idx = idx; v.last = last; v.irdy = irdy; v.busy = bsy;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs away from the rising edge and let them settle before sampling.
  task automatic drive(input logic r, input logic iv, input logic [127:0] blk, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_block = blk; out_ready = ordy;
    #1;
  endtask

  logic [31:0] exp_q[$];
  int          got;
  int          blk_sel;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    //                 rst   iv    blk     ordy  ov    word   idx    last  irdy  busy
    tbl.push_back(mk(1'b1, 1'b0, 128'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, B1,     1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W10,   2'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W11,   2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W12,   2'd2, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W13,   2'd3, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0));
    // backpressure at idx 1
    tbl.push_back(mk(1'b0, 1'b1, B1,     1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W10,   2'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b0, 1'b1, W11,   2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b0, 1'b1, W11,   2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b0, 1'b1, W11,   2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W11,   2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W12,   2'd2, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W13,   2'd3, 1'b1, 1'b1, 1'b1));
    // back-to-back, with a stall on the last word of the first block
    tbl.push_back(mk(1'b0, 1'b1, B1,     1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, B2,     1'b1, 1'b1, W10,   2'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, B2,     1'b1, 1'b1, W11,   2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, B2,     1'b1, 1'b1, W12,   2'd2, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, B2,     1'b0, 1'b1, W13,   2'd3, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, B2,     1'b1, 1'b1, W13,   2'd3, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W20,   2'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W21,   2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W22,   2'd2, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W23,   2'd3, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0));
    // two-cycle reset in mid-traffic
    tbl.push_back(mk(1'b0, 1'b1, B2,     1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b1, W20,   2'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 128'h0, 1'b1, 1'b1, W21,   2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 128'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].blk, tbl[i].ordy);
      check($sformatf("row%0d out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
      check($sformatf("row%0d out_word",  i), 128'(out_word),  128'(tbl[i].w));
      check($sformatf("row%0d out_idx",   i), 128'(out_idx),   128'(tbl[i].idx));
      check($sformatf("row%0d out_last",  i), 128'(out_last),  128'(tbl[i].last));
      check($sformatf("row%0d in_ready",  i), 128'(in_ready),  128'(tbl[i].irdy));
      check($sformatf("row%0d busy",      i), 128'(busy),      128'(tbl[i].busy));
    end

    // Early in_valid: B2 is offered from the first B1 word on, with irregular out_ready.
    exp_q = '{W10, W11, W12, W13, W20, W21, W22, W23};
    got = 0;
    blk_sel = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      drive(1'b0, (blk_sel < 2) ? 1'b1 : 1'b0, (blk_sel == 0) ? B1 : B2, (c % 3) != 1);
      if (blk_sel == 1 && out_valid && out_idx == 2'd1)
        check("early_in_ready_idx1", 128'(in_ready), 128'(1'b0));
      if (in_valid && in_ready) begin
        if (blk_sel == 1)
          check("b2_accept_on_last", 128'({out_valid, out_idx}), 128'({1'b1, 2'd3}));
        blk_sel++;
      end
      if (out_valid && out_ready) begin
        check($sformatf("sb_word%0d", got), 128'(out_word), 128'(exp_q[got]));
        check($sformatf("sb_idx%0d", got),  128'(out_idx),  128'(got % 4));
        got++;
      end
    end
    check("sb_word_count", 128'(got), 128'(8));

    // Reset at idx 2 discards the block; the next block restarts from its MS word.
    drive(1'b0, 1'b0, 128'h0, 1'b1);
    check("drain_idle", 128'(out_valid), 128'(1'b0));
    drive(1'b0, 1'b1, B2, 1'b1);
    drive(1'b0, 1'b0, 128'h0, 1'b1);
    drive(1'b0, 1'b0, 128'h0, 1'b1);
    drive(1'b1, 1'b0, 128'h0, 1'b1);
    check("pre_rst_word", 128'({out_valid, out_idx, out_word}), 128'({1'b1, 2'd2, W22}));
    drive(1'b0, 1'b0, 128'h0, 1'b1);
    check("post_rst_out", 128'({out_valid, out_idx, out_word, busy}), 128'(0));
    check("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
    drive(1'b0, 1'b1, B1, 1'b1);
    drive(1'b0, 1'b0, 128'h0, 1'b1);
    check("restart_word0", 128'({out_valid, out_idx, out_word}), 128'({1'b1, 2'd0, W10}));
    drive(1'b0, 1'b0, 128'h0, 1'b1);
    check("restart_word1", 128'({out_valid, out_idx, out_word}), 128'({1'b1, 2'd1, W11}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
